// File: rtl/mem_arbiter_pkg.sv
// Shared types and width constants for the SRAM arbiter between the Wishbone
// and ASCON masters.
package mem_arbiter_pkg;

  localparam int unsigned WordW = 32;
  localparam int unsigned AddrW = 5;

  typedef enum logic [2:0] {
    StIdle,
    StWbAcc,
    StWbDone,
    StAsLo,
    StAsHi,
    StAsDone
  } arb_state_e;

endpackage

// File: rtl/mem_arbiter.sv
// Round-robin arbiter sharing a 1R1W SRAM between a Wishbone word master and
// an ASCON 64-bit block master (two word accesses per block).
module mem_arbiter
  import mem_arbiter_pkg::*;
#(
  parameter int unsigned ADDR_W = AddrW,
  parameter int unsigned DATA_W = WordW
) (
  input  logic                clk,
  input  logic                RST,
  input  logic                wb_req,
  input  logic                wb_we,
  input  logic [ADDR_W-1:0]   wb_addr,
  input  logic [DATA_W-1:0]   wb_wdata,
  output logic                wb_ack,
  output logic [DATA_W-1:0]   wb_rdata,
  input  logic                as_req,
  input  logic                as_we,
  input  logic [ADDR_W-2:0]   as_blk,
  input  logic [2*DATA_W-1:0] as_wdata,
  output logic                as_ack,
  output logic [2*DATA_W-1:0] as_rdata,
  output logic                csb0,
  output logic [ADDR_W-1:0]   addr0,
  output logic [DATA_W-1:0]   din0,
  output logic                csb1,
  output logic [ADDR_W-1:0]   addr1,
  input  logic [DATA_W-1:0]   dout1,
  output logic                busy,
  output logic                grant
);

  arb_state_e        state_q, state_d;
  logic              csb0_q, csb0_d;
  logic              csb1_q, csb1_d;
  logic [ADDR_W-1:0] addr0_q, addr0_d;
  logic [ADDR_W-1:0] addr1_q, addr1_d;
  logic [DATA_W-1:0] din0_q, din0_d;
  logic              wb_ack_q, wb_ack_d;
  logic              as_ack_q, as_ack_d;
  logic              grant_q, grant_d;
  logic              last_as_q, last_as_d;
  logic              we_q, we_d;
  logic [DATA_W-1:0] lo_q, lo_d;
  logic              go_wb, go_as;

  always_comb begin
    state_d   = state_q;
    csb0_d    = 1'b1;
    csb1_d    = 1'b1;
    addr0_d   = '0;
    addr1_d   = '0;
    din0_d    = '0;
    wb_ack_d  = 1'b0;
    as_ack_d  = 1'b0;
    grant_d   = grant_q;
    last_as_d = last_as_q;
    we_d      = we_q;
    lo_d      = lo_q;
    go_wb     = 1'b0;
    go_as     = 1'b0;

    unique case (state_q)
      StIdle: begin
        // On a tie, the side that did not win last time gets the SRAM.
        go_wb = wb_req & (~as_req | last_as_q);
        go_as = as_req & ~go_wb;
        if (go_wb) begin
          state_d   = StWbAcc;
          grant_d   = 1'b0;
          last_as_d = 1'b0;
          we_d      = wb_we;
          if (wb_we) begin
            csb0_d  = 1'b0;
            addr0_d = wb_addr;
            din0_d  = wb_wdata;
          end else begin
            csb1_d  = 1'b0;
            addr1_d = wb_addr;
          end
        end else if (go_as) begin
          state_d   = StAsLo;
          grant_d   = 1'b1;
          last_as_d = 1'b1;
          we_d      = as_we;
          if (as_we) begin
            csb0_d  = 1'b0;
            addr0_d = {as_blk, 1'b0};
            din0_d  = as_wdata[DATA_W-1:0];
          end else begin
            csb1_d  = 1'b0;
            addr1_d = {as_blk, 1'b0};
          end
        end
      end
      StWbAcc: begin
        state_d  = StWbDone;
        wb_ack_d = 1'b1;
      end
      StWbDone: state_d = StIdle;
      StAsLo: begin
        state_d = StAsHi;
        if (we_q) begin
          csb0_d  = 1'b0;
          addr0_d = {as_blk, 1'b1};
          din0_d  = as_wdata[2*DATA_W-1:DATA_W];
        end else begin
          csb1_d  = 1'b0;
          addr1_d = {as_blk, 1'b1};
        end
      end
      StAsHi: begin
        state_d  = StAsDone;
        as_ack_d = 1'b1;
        // dout1 currently holds the low word fetched during StAsLo.
        if (!we_q) lo_d = dout1;
      end
      StAsDone: state_d = StIdle;
      default:  state_d = StIdle;
    endcase
  end

  always_ff @(posedge clk or posedge RST) begin
    if (RST) begin
      state_q   <= StIdle;
      csb0_q    <= 1'b1;
      csb1_q    <= 1'b1;
      addr0_q   <= '0;
      addr1_q   <= '0;
      din0_q    <= '0;
      wb_ack_q  <= 1'b0;
      as_ack_q  <= 1'b0;
      grant_q   <= 1'b0;
      last_as_q <= 1'b1;
      we_q      <= 1'b0;
      lo_q      <= '0;
    end else begin
      state_q   <= state_d;
      csb0_q    <= csb0_d;
      csb1_q    <= csb1_d;
      addr0_q   <= addr0_d;
      addr1_q   <= addr1_d;
      din0_q    <= din0_d;
      wb_ack_q  <= wb_ack_d;
      as_ack_q  <= as_ack_d;
      grant_q   <= grant_d;
      last_as_q <= last_as_d;
      we_q      <= we_d;
      lo_q      <= lo_d;
    end
  end

  assign csb0     = csb0_q;
  assign csb1     = csb1_q;
  assign addr0    = addr0_q;
  assign addr1    = addr1_q;
  assign din0     = din0_q;
  assign wb_ack   = wb_ack_q;
  assign as_ack   = as_ack_q;
  assign grant    = grant_q;
  assign busy     = (state_q != StIdle);
  assign wb_rdata = (wb_ack_q && !we_q) ? dout1 : '0;
  assign as_rdata = (as_ack_q && !we_q) ? {dout1, lo_q} : '0;

endmodule
